// File: rtl/piso_serializer_16_async_pkg.sv
// Shared constants and state encoding for the enabled serial shift link.
// The receive-side framing logic imports CNT_W from here as well.
package piso_serializer_16_async_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_serializer_16_async_counter.sv
// Bit-position up-counter with async reset, sync clear/restart, enable and terminal count.
// It wraps to zero on an enabled terminal tick, so it never depends on natural overflow.
module bit_counter_enable_async #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TERM  = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             restart,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tc_s;

    assign tc_s = (cnt_q == TERM_C);

    // Next count: clear and restart both return to zero, clear having priority.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            if (tc_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE_C;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_s;

endmodule

// File: rtl/piso_serializer_16_async.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it
// out MSB-first, one bit per enable tick, with a one-cycle done pulse at the end.
module piso_serializer_16_async
    import piso_serializer_16_async_pkg::*;
#(
    parameter int unsigned P_WIDTH = WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               clear,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [P_WIDTH-1:0] data_in,
    output logic               sdo,
    output logic               frame,
    output logic               done
);

    localparam int unsigned P_CNT_W = $clog2(P_WIDTH);

    state_e               state_q;
    state_e               state_d;
    logic [P_WIDTH-1:0]   shreg_q;
    logic [P_WIDTH-1:0]   shreg_d;
    logic                 done_q;
    logic                 done_d;
    logic [P_CNT_W-1:0]   cnt_s;
    logic                 cnt_tc_s;
    logic                 accept_s;
    logic                 tick_s;

    assign accept_s = (state_q == ST_IDLE)  && load_valid && !clear;
    assign tick_s   = (state_q == ST_SHIFT) && enable;

    bit_counter_enable_async #(
        .CNT_W (P_CNT_W),
        .TERM  (P_WIDTH - 1)
    ) u_bit_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .restart (accept_s),
        .enable  (tick_s),
        .cnt     (cnt_s),
        .tc      (cnt_tc_s)
    );

    // Next-state and shift-register logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shreg_d = data_in;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    shreg_d = {shreg_q[P_WIDTH-2:0], 1'b0};
                    if (cnt_tc_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            shreg_d = '0;
        end else begin
            state_d = state_d;
        end
    end

    // done marks the cycle after the terminal tick; an aborted word never raises it.
    always_comb begin
        done_d = 1'b0;
        if (clear) begin
            done_d = 1'b0;
        end else if (tick_s && cnt_tc_s) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State, shift register and done flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    // shreg is all zeros whenever the FSM is idle, so sdo needs no gating.
    assign sdo        = shreg_q[P_WIDTH-1];
    assign frame      = (state_q == ST_SHIFT);
    assign load_ready = (state_q == ST_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer_16_async.sv
// Scoreboard bench: stimulus queues expected words, a far-end SIPO monitor checks on done.
module tb_piso_serializer_16_async;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic        clear;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] data_in;
    logic        sdo;
    logic        frame;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_word_q[$];
    int          exp_len_q[$];

    logic [15:0] fe_q = 16'h0000;
    int          frame_run = 0;
    logic        prev_frame = 1'b0;
    logic        prev_en = 1'b0;
    logic        prev_sdo = 1'b0;
    logic        prev_done = 1'b0;

    piso_serializer_16_async dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .sdo        (sdo),
        .frame      (frame),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a word for one handshake edge; expectation queued only when it should complete.
    task automatic load_word(input logic [15:0] w, input int len, input bit expect_it);
        load_valid = 1'b1;
        data_in    = w;
        if (expect_it) begin
            exp_word_q.push_back(w);
            exp_len_q.push_back(len);
        end
        step(1);
        load_valid = 1'b0;
        data_in    = 16'h0000;
    endtask

    // Far-end receiver and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (frame && prev_frame && !prev_en) begin
                chk("sdo_hold", {31'd0, sdo}, {31'd0, prev_sdo});
            end
            if (done && prev_done) begin
                chk("done_one_cycle", 32'd2, 32'd1);
            end
            if (frame && enable) begin
                fe_q = {fe_q[14:0], sdo};
            end
            if (frame) begin
                frame_run++;
            end
            if (done) begin
                if (exp_word_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("far_end_word", {16'd0, fe_q}, {16'd0, exp_word_q.pop_front()});
                    chk("frame_len", frame_run, exp_len_q.pop_front());
                end
                chk("done_idle_sdo", {31'd0, sdo}, 32'd0);
                chk("done_ready", {31'd0, load_ready}, 32'd1);
                frame_run = 0;
            end else if (!frame) begin
                frame_run = 0;
            end
        end else begin
            frame_run = 0;
        end
        prev_frame = frame;
        prev_en    = enable;
        prev_sdo   = sdo;
        prev_done  = done;
    end

    initial begin
        resetn     = 1'b0;
        enable     = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        data_in    = 16'h0000;
        step(2);
        chk("rst_sdo", {31'd0, sdo}, 32'd0);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        resetn = 1'b1;
        step(2);

        // Continuous enable loopback.
        enable = 1'b1;
        load_word(16'hA5C3, 16, 1'b1);
        chk("a5c3_first_bit", {31'd0, sdo}, 32'd1);
        chk("a5c3_busy", {31'd0, load_ready}, 32'd0);
        step(17);

        // Gapped enable, one tick every third cycle.
        enable = 1'b0;
        load_word(16'h8001, 46, 1'b1);
        for (int i = 0; i < 48; i++) begin
            enable = (i % 3 == 0);
            step(1);
        end

        // Load attempts while busy must be ignored.
        enable = 1'b1;
        load_word(16'h1234, 16, 1'b1);
        step(3);
        load_valid = 1'b1;
        data_in    = 16'hFFFF;
        chk("busy_ready", {31'd0, load_ready}, 32'd0);
        step(2);
        load_valid = 1'b0;
        data_in    = 16'h0000;
        step(12);

        // Back-to-back: second word presented in the done cycle.
        load_word(16'h00FF, 16, 1'b1);
        step(16);
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_gap_frame", {31'd0, frame}, 32'd0);
        load_word(16'hFF00, 16, 1'b1);
        chk("b2b_second_frame", {31'd0, frame}, 32'd1);
        step(17);

        // Abort with clear after 5 ticks; no done may follow.
        load_word(16'hBEEF, 16, 1'b0);
        step(5);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("abort_sdo", {31'd0, sdo}, 32'd0);
        chk("abort_frame", {31'd0, frame}, 32'd0);
        chk("abort_ready", {31'd0, load_ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        step(2);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        clear      = 1'b1;
        load_valid = 1'b1;
        data_in    = 16'h7777;
        step(1);
        clear      = 1'b0;
        load_valid = 1'b0;
        chk("clear_rejects_load", {31'd0, frame}, 32'd0);
        load_word(16'h0001, 16, 1'b1);
        step(17);

        // Async reset mid-word, between clock edges.
        load_word(16'hC0DE, 16, 1'b0);
        step(9);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_sdo", {31'd0, sdo}, 32'd0);
        chk("arst_frame", {31'd0, frame}, 32'd0);
        chk("arst_ready", {31'd0, load_ready}, 32'd1);
        chk("arst_done", {31'd0, done}, 32'd0);
        step(2);
        resetn = 1'b1;
        step(1);
        load_word(16'h5A5A, 16, 1'b1);
        step(17);

        for (int i = 0; i < 50 && exp_word_q.size() != 0; i++) begin
            step(1);
        end
        chk("scoreboard_drained", exp_word_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
